// File: rtl/draw_ground_pkg.sv
// draw_ground_pkg: screen geometry, tile constants, colours and ground tile helpers shared by drawing stages
package draw_ground_pkg;

  localparam int GROUND_Y  = 380;
  localparam int YRES      = 480;
  localparam int TILE_BITS = 4;
  localparam int TILE_SIZE = 1 << TILE_BITS;

  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;
  localparam logic [23:0] BLACK     = 24'h000000;
  localparam logic [23:0] WHITE     = 24'hFFFFFF;

  // ROM address {tile_sel, ty, tx}; the 11-bit sum wraps naturally when truncated to tx
  function automatic logic [8:0] tile_addr(logic [9:0] hc, logic [9:0] xo, logic [9:0] row);
    logic [10:0] sum;
    sum = {1'b0, hc} + {1'b0, xo};
    return {row >= 10'(TILE_SIZE), row[TILE_BITS-1:0], sum[TILE_BITS-1:0]};
  endfunction

  // Tile art: grass (sel 0) has transparent blade gaps in its top-right texels, dirt is fully opaque
  function automatic logic [23:0] tile_texel(logic [8:0] a);
    if (!a[8] && a[7:4] == 4'd0 && a[3:2] == 2'b11) return KEY_COLOR;
    return a[8] ? {8'h80, a[7:0], 8'h30} : {8'h10, a[7:0], 8'h20};
  endfunction

endpackage

// File: rtl/draw_ground_tile_rom.sv
// ground_tile_rom: 512x24 synchronous-read ROM holding the grass and dirt tiles
module ground_tile_rom
  import draw_ground_pkg::*;
(
  input  logic        clk,
  input  logic [8:0]  addr,
  output logic [23:0] data
);

  logic [23:0] mem [512];

  // contents are fixed tile art, elaborated as constants
  always_comb
    for (int i = 0; i < 512; i++) mem[i] = tile_texel(9'(i));

  // registered read so the texel lines up with the stage-1 pipeline registers
  always_ff @(posedge clk)
    data <= mem[addr];

endmodule

// File: rtl/draw_ground.sv
// draw_ground: paints the scrolling tiled ground strip over the background pixel stream
module draw_ground
  import draw_ground_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount_in,
  input  logic        hsync_in,
  input  logic [9:0]  vcount_in,
  input  logic        vsync_in,
  input  logic        blnk_in,
  input  logic [23:0] rgb_in,
  input  logic [9:0]  xoffset,
  output logic [9:0]  hcount_out,
  output logic        hsync_out,
  output logic [9:0]  vcount_out,
  output logic        vsync_out,
  output logic        blnk_out,
  output logic [23:0] rgb_out
);

  logic        vsync_prev;
  logic [9:0]  xoff_q;
  logic [9:0]  hcount_d, vcount_d;
  logic        hsync_d, vsync_d, blnk_d, ground_d;
  logic [23:0] rgb_d, rom_data;
  logic        in_ground;
  logic [8:0]  rom_addr;

  assign in_ground = (vcount_in >= 10'(GROUND_Y)) && (vcount_in < 10'(YRES)) && !blnk_in;
  assign rom_addr  = tile_addr(hcount_in, xoff_q, vcount_in - 10'(GROUND_Y));

  ground_tile_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // scroll offset is frozen for a whole frame, latched on the vsync rising edge
  always_ff @(posedge clk)
    if (!rst) begin
      vsync_prev <= 1'b0;
      xoff_q     <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) xoff_q <= xoffset;
    end

  // stage 1: delay timing and background colour alongside the ROM read
  always_ff @(posedge clk)
    if (!rst) begin
      hcount_d <= '0;
      hsync_d  <= 1'b0;
      vcount_d <= '0;
      vsync_d  <= 1'b0;
      blnk_d   <= 1'b0;
      rgb_d    <= '0;
      ground_d <= 1'b0;
    end else begin
      hcount_d <= hcount_in;
      hsync_d  <= hsync_in;
      vcount_d <= vcount_in;
      vsync_d  <= vsync_in;
      blnk_d   <= blnk_in;
      rgb_d    <= rgb_in;
      ground_d <= in_ground;
    end

  // stage 2: composite opaque ground texels over the background, black during blanking
  always_ff @(posedge clk)
    if (!rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      blnk_out   <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_d;
      hsync_out  <= hsync_d;
      vcount_out <= vcount_d;
      vsync_out  <= vsync_d;
      blnk_out   <= blnk_d;
      rgb_out    <= blnk_d ? BLACK : (ground_d && rom_data != KEY_COLOR) ? rom_data : rgb_d;
    end

endmodule

// File: tb/tb_draw_ground.sv
// tb_draw_ground: scoreboard bench for the ground compositing stage
module tb_draw_ground;

  typedef struct packed {
    logic [9:0]  hc;
    logic        hs;
    logic [9:0]  vc;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } px_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hcount_in = '0, vcount_in = '0, xoffset = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, blnk_in = 1'b0;
  logic [23:0] rgb_in = '0;
  logic [9:0]  hcount_out, vcount_out;
  logic        hsync_out, vsync_out, blnk_out;
  logic [23:0] rgb_out;

  px_t  exp_q[$];
  px_t  act_q[$];
  int   compared = 0;
  int   mismatched = 0;
  logic rec = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [9:0] m_xoff = '0;
  logic       m_vprev = 1'b0;

  draw_ground dut (
    .clk        (clk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .blnk_in    (blnk_in),
    .rgb_in     (rgb_in),
    .xoffset    (xoffset),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .blnk_out   (blnk_out),
    .rgb_out    (rgb_out)
  );

  always #5 clk = ~clk;

  // collect the output belonging to a recorded input two edges earlier
  always @(posedge clk) begin
    if (!rst) begin
      v1 = 1'b0;
      v2 = 1'b0;
    end else begin
      v2 = v1;
      v1 = rec;
    end
    #1;
    if (v2) act_q.push_back({hcount_out, hsync_out, vcount_out, vsync_out, blnk_out, rgb_out});
  end

  function automatic logic [23:0] texel(logic sel, logic [3:0] ty, logic [3:0] tx);
    if (!sel && ty == 4'd0 && tx >= 4'd12) return 24'hFF00FF;
    return sel ? {8'h80, ty, tx, 8'h30} : {8'h10, ty, tx, 8'h20};
  endfunction

  // called right after a negedge: apply inputs, predict output, advance to next negedge
  task automatic drive(input logic [9:0] hc, input logic [9:0] vc, input logic hs, input logic vs,
                       input logic bl, input logic [23:0] rgb, input logic [9:0] xo);
    px_t e;
    logic [9:0] row;
    logic [3:0] tx;
    logic [23:0] t;
    hcount_in = hc; vcount_in = vc; hsync_in = hs; vsync_in = vs;
    blnk_in = bl; rgb_in = rgb; xoffset = xo; rec = 1'b1;
    row = vc - 10'd380;
    tx  = 4'((int'(hc) + int'(m_xoff)) % 16);
    t   = texel(row >= 10'd16, row[3:0], tx);
    e.hc = hc; e.hs = hs; e.vc = vc; e.vs = vs; e.bl = bl;
    e.rgb = bl ? 24'h0 : (vc >= 10'd380 && vc < 10'd480 && t != 24'hFF00FF) ? t : rgb;
    exp_q.push_back(e);
    if (vs && !m_vprev) m_xoff = xo;
    m_vprev = vs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rec = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      hcount_in = 10'($urandom); vcount_in = 10'($urandom); rgb_in = 24'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); blnk_in = 1'($urandom);
      xoffset = 10'($urandom); rec = 1'b0;
      @(posedge clk); #1;
      compared++;
      if ({hcount_out, hsync_out, vcount_out, vsync_out, blnk_out, rgb_out} !== 47'h0) begin
        mismatched++;
        $display("FAIL reset_outputs: got %h required 0",
                 {hcount_out, hsync_out, vcount_out, vsync_out, blnk_out, rgb_out});
      end
      @(negedge clk);
    end
    vsync_in = 1'b0;
    rst = 1'b1; m_xoff = '0; m_vprev = 1'b0;
    drive(10'd0, 10'd10, 1'b0, 1'b0, 1'b0, 24'h0505FF, 10'd0);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL reset_release: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL reset_release: got %h required %h", a, e); end
      end
    end
  endtask

  task automatic test_passthrough();
    for (int h = 0; h < 640; h++)
      drive(10'(h), 10'd200, h >= 600, 1'b0, 1'b0, 24'(h * 24'h010203) ^ 24'h5A5A5A, 10'($urandom));
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL passthrough: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL passthrough: got %h required %h", a, e); end
      end
    end
  endtask

  task automatic test_ground_addressing();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0, 10'd0);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0, 10'd0);
    drive(10'd5,  10'd380, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 10'd0);
    drive(10'd21, 10'd400, 1'b0, 1'b0, 1'b0, 24'hABCDEF, 10'd0);
    drive(10'd9,  10'd379, 1'b0, 1'b0, 1'b0, 24'h010101, 10'd0);
    drive(10'd9,  10'd396, 1'b0, 1'b0, 1'b0, 24'h020202, 10'd0);
    drive(10'd9,  10'd479, 1'b0, 1'b0, 1'b0, 24'h030303, 10'd0);
    drive(10'd9,  10'd480, 1'b0, 1'b0, 1'b0, 24'h040404, 10'd0);
    drive(10'd639, 10'd395, 1'b1, 1'b0, 1'b0, 24'h050505, 10'd0);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL ground_addr: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL ground_addr: got %h required %h", a, e); end
      end
    end
  endtask

  task automatic test_transparency_blank();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0, 10'd0);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0, 10'd0);
    drive(10'd12, 10'd380, 1'b0, 1'b1, 1'b0, 24'h123456, 10'd0);
    drive(10'd15, 10'd380, 1'b0, 1'b1, 1'b0, 24'h654321, 10'd0);
    drive(10'd11, 10'd380, 1'b0, 1'b1, 1'b0, 24'h123456, 10'd0);
    drive(10'd12, 10'd381, 1'b0, 1'b1, 1'b0, 24'h123456, 10'd0);
    drive(10'd700, 10'd390, 1'b0, 1'b1, 1'b1, 24'h777777, 10'd0);
    drive(10'd5, 10'd420, 1'b0, 1'b1, 1'b1, 24'h888888, 10'd0);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL transp_blank: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL transp_blank: got %h required %h", a, e); end
      end
    end
  endtask

  task automatic test_scroll_wrap();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0, 10'd1020);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0, 10'd1020);
    drive(10'd7, 10'd380, 1'b0, 1'b1, 1'b0, 24'h111111, 10'd1020);
    drive(10'd7, 10'd380, 1'b0, 1'b1, 1'b0, 24'h111111, 10'd8);
    drive(10'd1, 10'd380, 1'b0, 1'b1, 1'b0, 24'h111111, 10'd8);
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0, 10'd8);
    drive(10'd1, 10'd380, 1'b0, 1'b1, 1'b0, 24'h222222, 10'd8);
    drive(10'd1, 10'd380, 1'b0, 1'b1, 1'b0, 24'h222222, 10'd8);
    drive(10'd1, 10'd380, 1'b0, 1'b0, 1'b0, 24'h222222, 10'd3);
    drive(10'd2, 10'd385, 1'b0, 1'b1, 1'b0, 24'h333333, 10'd3);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL scroll_wrap: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL scroll_wrap: got %h required %h", a, e); end
      end
    end
  endtask

  task automatic test_midframe_reset();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 24'h0, 10'd5);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 24'h0, 10'd5);
    drive(10'd3, 10'd390, 1'b0, 1'b0, 1'b0, 24'h444444, 10'd5);
    drive(10'd4, 10'd390, 1'b0, 1'b0, 1'b0, 24'h444444, 10'd5);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL pre_reset: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL pre_reset: got %h required %h", a, e); end
      end
    end
    drive(10'd5, 10'd390, 1'b0, 1'b0, 1'b0, 24'h999999, 10'd5);
    exp_q.delete();
    rst = 1'b0; rec = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({hcount_out, hsync_out, vcount_out, vsync_out, blnk_out, rgb_out} !== 47'h0) begin
      mismatched++;
      $display("FAIL midframe_reset: got %h required 0",
               {hcount_out, hsync_out, vcount_out, vsync_out, blnk_out, rgb_out});
    end
    @(negedge clk);
    rst = 1'b1; m_xoff = '0; m_vprev = 1'b0;
    drive(10'd3, 10'd390, 1'b0, 1'b0, 1'b0, 24'h555555, 10'd5);
    drive(10'd8, 10'd390, 1'b0, 1'b0, 1'b0, 24'h555555, 10'd5);
    drive(10'd12, 10'd398, 1'b0, 1'b0, 1'b0, 24'h555555, 10'd5);
    idle(3);
    while (exp_q.size() > 0) begin
      px_t e = exp_q.pop_front();
      compared++;
      if (act_q.size() == 0) begin mismatched++; $display("FAIL post_reset: no output, required %h", e); end
      else begin
        px_t a = act_q.pop_front();
        if (a !== e) begin mismatched++; $display("FAIL post_reset: got %h required %h", a, e); end
      end
    end
    compared++;
    if (act_q.size() != 0) begin
      mismatched++;
      $display("FAIL extra_outputs: got %0d leftover required 0", act_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_ground_addressing();
    test_transparency_blank();
    test_scroll_wrap();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
